// File: rtl/hive_uart_pkg.sv
// Shared types and register field positions for the rbus UART TX port.
package hive_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

   // Status flag offsets counted down from the rbus MSB: flag lives at bit ALU_W-1-x.
   localparam int NFULL_BIT = 0;
   localparam int BUSY_BIT  = 1;
   localparam int OVF_BIT   = 2;

   localparam int DIV_W     = 16;
   localparam int FLUSH_BIT = 16;

   // A zero divisor would never end a bit; treat it as one clock per bit.
   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

endpackage

// File: rtl/hive_uart_tx_fifo_mem.sv
// Synchronous FIFO with level output, flush, and full judged on the pre-cycle level.
module hive_uart_tx_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push_ok, pop_ok;

   assign full    = (level == (ADDR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Flush wins over a same-cycle pop so the FIFO always ends empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
         level <= level + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/hive_reg_uart_tx_fifo.sv
// rbus-mapped serial TX port: data/status at ADDR, divisor/flush config at ADDR+1.
// Optional MIDI running-status compression: define HIVE_UART_RUNNING_STATUS_EN (DATA_W = 8 only).
module hive_reg_uart_tx_fifo
   import hive_uart_pkg::*;
#(
   parameter int ALU_W       = 32,
   parameter int RBUS_ADDR_W = 8,
   parameter int ADDR        = 0,
   parameter int DATA_W      = 8,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_ADDR_W = 4,
   parameter int DIV_INIT    = 1600
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
   input  logic                   rbus_wr_i,
   input  logic                   rbus_rd_i,
   input  logic [ALU_W-1:0]       rbus_wr_data_i,
   output logic [ALU_W-1:0]       rbus_rd_data_o,
   output logic                   tx_o
);
   localparam int LVL_W = FIFO_ADDR_W + 1;
   localparam int IDX_W = 5;

   logic              sel_data, sel_cfg, push, flush, pop, full, empty, ovf, discard;
   logic [DATA_W-1:0] head, shreg;
   logic [LVL_W-1:0]  level;
   logic [DIV_W-1:0]  divisor, bit_div, cnt;
   logic [IDX_W-1:0]  idx;
   logic [ALU_W-1:0]  status;
   logic              tx, tx_nx, bit_end, load, shift, idx_clr, idx_inc;
   tx_state_e         state, state_nx;
   logic              unused;

   assign sel_data = (rbus_addr_i == RBUS_ADDR_W'(ADDR));
   assign sel_cfg  = (rbus_addr_i == RBUS_ADDR_W'(ADDR + 1));
   assign push     = rbus_wr_i && sel_data;
   assign flush    = rbus_wr_i && sel_cfg && rbus_wr_data_i[FLUSH_BIT];
   assign unused   = ^rbus_wr_data_i[ALU_W-1:FLUSH_BIT+1];

   hive_uart_tx_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(FIFO_ADDR_W)) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (rbus_wr_data_i[DATA_W-1:0]),
      .rd_data (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

`ifdef HIVE_UART_RUNNING_STATUS_EN
   logic [7:0] run_status;
   logic       is_chan, is_sys;

   assign is_chan = head[7] && (head[7:4] != 4'hF);
   assign is_sys  = (head[7:3] == 5'b11110);
   assign discard = is_chan && (head[7:0] == run_status);

   // Zero never matches a channel status byte, so it doubles as "no status stored".
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    run_status <= '0;
      else if (flush)  run_status <= '0;
      else if (pop) begin
         if (is_chan)     run_status <= head[7:0];
         else if (is_sys) run_status <= '0;
      end
   end
`else
   assign discard = 1'b0;
`endif

   always_comb begin
      status = '0;
      status[ALU_W-1-NFULL_BIT] = !full;
      status[ALU_W-1-BUSY_BIT]  = !empty || (state != IDLE);
      status[ALU_W-1-OVF_BIT]   = ovf;
      status[LVL_W-1:0]         = level;
   end

   // A write rejected this cycle re-arms overflow even when a status read clears it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf            <= 1'b0;
         divisor        <= DIV_W'(DIV_INIT);
         rbus_rd_data_o <= '0;
      end else begin
         ovf <= (push && full) || (ovf && !(rbus_rd_i && sel_data));
         if (rbus_wr_i && sel_cfg) divisor <= clamp_div(rbus_wr_data_i[DIV_W-1:0]);
         if (rbus_rd_i && sel_data)     rbus_rd_data_o <= status;
         else if (rbus_rd_i && sel_cfg) rbus_rd_data_o <= ALU_W'(divisor);
         else                           rbus_rd_data_o <= '0;
      end
   end

   assign bit_end = (cnt == bit_div - DIV_W'(1));

   always_comb begin
      state_nx = state;
      tx_nx    = tx;
      pop      = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;
      idx_clr  = 1'b0;
      idx_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (!discard) begin
                  load     = 1'b1;
                  state_nx = START;
                  tx_nx    = 1'b0;
               end
            end
         end
         START: begin
            if (bit_end) begin
               state_nx = DATA;
               tx_nx    = shreg[0];
               shift    = 1'b1;
               idx_clr  = 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx == IDX_W'(DATA_W - 1)) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
                  idx_clr  = 1'b1;
               end else begin
                  tx_nx   = shreg[0];
                  shift   = 1'b1;
                  idx_inc = 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (idx == IDX_W'(STOP_BITS - 1)) begin
                  // Back-to-back frames: the next start bit follows the last stop bit directly.
                  tx_nx    = 1'b1;
                  state_nx = IDLE;
                  if (!empty) begin
                     pop = 1'b1;
                     if (!discard) begin
                        load     = 1'b1;
                        state_nx = START;
                        tx_nx    = 1'b0;
                     end
                  end
               end else begin
                  idx_inc = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         tx    <= 1'b1;
      end else begin
         state <= state_nx;
         tx    <= tx_nx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shreg   <= '0;
         bit_div <= DIV_W'(1);
         cnt     <= '0;
         idx     <= '0;
      end else begin
         if (load) begin
            shreg   <= head;
            bit_div <= divisor;
         end else if (shift) begin
            shreg <= shreg >> 1;
         end
         cnt <= (load || bit_end) ? '0 : cnt + DIV_W'(1);
         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + IDX_W'(1);
      end
   end

   assign tx_o = tx;

endmodule

// File: tb/tb_hive_reg_uart_tx_fifo.sv
// Directed bench for hive_reg_uart_tx_fifo; a background decoder rebuilds frames from tx_o.
module tb_hive_reg_uart_tx_fifo;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  addr = '0;
   logic        wr = 1'b0, rd = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        tx;

   int vectors = 0, errors = 0;
   int cyc = 0;
   int dec_div = 4;
   int rx_err = 0;
   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic [7:0] bq[$];

   always #5 clk = ~clk;

   hive_reg_uart_tx_fifo dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .rbus_addr_i    (addr),
      .rbus_wr_i      (wr),
      .rbus_rd_i      (rd),
      .rbus_wr_data_i (wdata),
      .rbus_rd_data_o (rdata),
      .tx_o           (tx)
   );

   // Frame decoder: samples each bit at its centre using dec_div latched at the start edge.
   initial begin : decoder
      bit         act;
      int         t0, dl, k, b;
      logic [7:0] sh;
      act = 0; t0 = 0; dl = 4; sh = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) act = 0;
         else if (!act) begin
            if (tx === 1'b0) begin act = 1; t0 = cyc; dl = dec_div; sh = '0; end
         end else begin
            k = cyc - t0;
            if (k % dl == dl / 2) begin
               b = k / dl;
               if (b == 0) begin
                  if (tx !== 1'b0) rx_err++;
               end else if (b <= 8) sh[b-1] = tx;
               else begin
                  if (tx !== 1'b1) rx_err++;
                  rx_q.push_back(sh);
                  rx_t.push_back(t0);
                  act = 0;
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete(); rx_t.delete(); rx_err = 0;
      @(negedge clk);
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk); addr = a; wdata = d; wr = 1'b1;
      @(negedge clk); wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk); addr = a; rd = 1'b1;
      @(negedge clk); rd = 1'b0; d = rdata;
   endtask

   task automatic burst();
      foreach (bq[i]) begin
         @(negedge clk); addr = 8'd0; wdata = {24'd0, bq[i]}; wr = 1'b1;
      end
      @(negedge clk); wr = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #1 rst_n = 1'b0;
      @(negedge clk);
      vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL reset_status: got %h want 80000000", d); end
      rd_reg(8'd1, d);
      vectors++; if (d !== 32'd1600) begin errors++; $display("FAIL reset_div: got %0d want 1600", d); end
   endtask

   task automatic test_frame();
      logic [9:0]  seq;
      logic [31:0] d;
      do_reset();
      wr_reg(8'd1, 32'd4); dec_div = 4;
      wr_reg(8'd0, 32'h55);
      vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL latency_early: got %b want 1", tx); end
      seq = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         vectors++;
         if (tx !== seq[i/4]) begin errors++; $display("FAIL frame_bit%0d: got %b want %b", i, tx, seq[i/4]); end
      end
      @(negedge clk);
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL frame_idle: got %h want 80000000", d); end
   endtask

   task automatic test_config();
      logic [31:0] d;
      do_reset();
      wr_reg(8'd1, 32'd0); rd_reg(8'd1, d);
      vectors++; if (d !== 32'd1) begin errors++; $display("FAIL div_zero: got %h want 1", d); end
      wr_reg(8'd1, 32'hFFFE_ABCD); rd_reg(8'd1, d);
      vectors++; if (d !== 32'h0000_ABCD) begin errors++; $display("FAIL div_mask: got %h want 0000abcd", d); end
      @(negedge clk);
      vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_idle: got %h want 0", rdata); end
      rd_reg(8'd5, d);
      vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rd_nomatch: got %h want 0", d); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      do_reset();
      wr_reg(8'd1, 32'd1000); dec_div = 1000;
      bq.delete();
      for (int i = 0; i < 16; i++) bq.push_back(8'(i + 1));
      burst();
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'hC000_000F) begin errors++; $display("FAIL ovf_lvl15: got %h want c000000f", d); end
      wr_reg(8'd0, 32'hAA); rd_reg(8'd0, d);
      vectors++; if (d !== 32'h4000_0010) begin errors++; $display("FAIL ovf_full: got %h want 40000010", d); end
      wr_reg(8'd0, 32'hBB); rd_reg(8'd0, d);
      vectors++; if (d !== 32'h6000_0010) begin errors++; $display("FAIL ovf_set: got %h want 60000010", d); end
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'h4000_0010) begin errors++; $display("FAIL ovf_clear: got %h want 40000010", d); end
      @(negedge clk); addr = 8'd0; wdata = 32'hCC; wr = 1'b1; rd = 1'b1;
      @(negedge clk); wr = 1'b0; rd = 1'b0; d = rdata;
      vectors++; if (d !== 32'h4000_0010) begin errors++; $display("FAIL ovf_same_rd: got %h want 40000010", d); end
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'h6000_0010) begin errors++; $display("FAIL ovf_survive: got %h want 60000010", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int          last;
      int          lv[$];
      logic [7:0]  exp_b[4];
      do_reset();
      wr_reg(8'd1, 32'd4); dec_div = 4;
      wr_reg(8'd0, 32'h01);
      bq = {8'hA5, 8'h3C, 8'h81};
      burst();
      last = -1;
      for (int i = 0; i < 300; i++) begin
         rd_reg(8'd0, d);
         if (int'(d[4:0]) != last) begin last = int'(d[4:0]); lv.push_back(last); end
         if (d[30] == 1'b0) break;
      end
      vectors++; if (lv.size() != 4) begin errors++; $display("FAIL b2b_lvl_count: got %0d want 4", lv.size()); end
      for (int i = 0; i < 4 && i < lv.size(); i++) begin
         vectors++; if (lv[i] != 3 - i) begin errors++; $display("FAIL b2b_lvl%0d: got %0d want %0d", i, lv[i], 3 - i); end
      end
      exp_b = '{8'h01, 8'hA5, 8'h3C, 8'h81};
      vectors++; if (rx_q.size() != 4) begin errors++; $display("FAIL b2b_frames: got %0d want 4", rx_q.size()); end
      for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
         vectors++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
      end
      for (int i = 0; i + 1 < rx_t.size(); i++) begin
         vectors++; if (rx_t[i+1] - rx_t[i] != 40) begin errors++; $display("FAIL b2b_gap%0d: got %0d want 40", i, rx_t[i+1] - rx_t[i]); end
      end
      vectors++; if (rx_err != 0) begin errors++; $display("FAIL b2b_framing: got %0d want 0", rx_err); end
   endtask

   task automatic test_div_change();
      logic [31:0] d;
      do_reset();
      wr_reg(8'd1, 32'd4); dec_div = 4;
      bq = {8'h3A, 8'hC5};
      burst();
      wr_reg(8'd1, 32'd8); dec_div = 8;
      wait_rx(2, 400);
      vectors++; if (rx_q.size() != 2) begin errors++; $display("FAIL div_frames: got %0d want 2", rx_q.size()); end
      if (rx_q.size() == 2) begin
         vectors++; if (rx_q[0] !== 8'h3A) begin errors++; $display("FAIL div_byte0: got %h want 3a", rx_q[0]); end
         vectors++; if (rx_q[1] !== 8'hC5) begin errors++; $display("FAIL div_byte1: got %h want c5", rx_q[1]); end
         vectors++; if (rx_t[1] - rx_t[0] != 40) begin errors++; $display("FAIL div_len0: got %0d want 40", rx_t[1] - rx_t[0]); end
      end
      vectors++; if (rx_err != 0) begin errors++; $display("FAIL div_framing: got %0d want 0", rx_err); end
      rd_reg(8'd1, d);
      vectors++; if (d !== 32'd8) begin errors++; $display("FAIL div_read: got %0d want 8", d); end
   endtask

   task automatic test_flush();
      logic [31:0] d;
      do_reset();
      wr_reg(8'd1, 32'd4); dec_div = 4;
      wr_reg(8'd0, 32'h11);
      bq = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
      burst();
      wr_reg(8'd1, 32'h0001_0004);
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'hC000_0000) begin errors++; $display("FAIL flush_status: got %h want c0000000", d); end
      repeat (200) @(negedge clk);
      vectors++; if (rx_q.size() != 1) begin errors++; $display("FAIL flush_frames: got %0d want 1", rx_q.size()); end
      if (rx_q.size() >= 1) begin
         vectors++; if (rx_q[0] !== 8'h11) begin errors++; $display("FAIL flush_byte: got %h want 11", rx_q[0]); end
      end
      rd_reg(8'd0, d);
      vectors++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL flush_idle: got %h want 80000000", d); end
   endtask

   task automatic test_running_status();
      logic [7:0]  exp_q[$];
      logic [31:0] d;
      do_reset();
      wr_reg(8'd1, 32'd2); dec_div = 2;
      bq = {8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40, 8'hF8, 8'h90, 8'h41, 8'hF0, 8'h90, 8'h42};
`ifdef HIVE_UART_RUNNING_STATUS_EN
      exp_q = {8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'hF8, 8'h41, 8'hF0, 8'h90, 8'h42};
`else
      exp_q = bq;
`endif
      burst();
      d = 32'hFFFF_FFFF;
      for (int i = 0; i < 300 && d[30] !== 1'b0; i++) rd_reg(8'd0, d);
      vectors++; if (d[30] !== 1'b0) begin errors++; $display("FAIL rs_idle: got busy %b want 0", d[30]); end
      vectors++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rs_frames: got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         vectors++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rs_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      vectors++; if (rx_err != 0) begin errors++; $display("FAIL rs_framing: got %0d want 0", rx_err); end
   endtask

   task automatic test_async_reset();
      do_reset();
      wr_reg(8'd1, 32'd4); dec_div = 4;
      wr_reg(8'd0, 32'h00);
      repeat (6) @(negedge clk);
      vectors++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b want 0", tx); end
      addr = 8'd1; rd = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL async_tx: got %b want 1", tx); end
      vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h want 0", rdata); end
      rd = 1'b0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_frame();
      test_config();
      test_overflow();
      test_back_to_back();
      test_div_change();
      test_flush();
      test_running_status();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
